// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus bundle: instruction-memory port, fetch-to-decode handshake,
// redirect/halt control and status. master = fetch_ctrl, slave = the environment
// (instruction memory, decode stage and branch unit) that drives the inputs.
interface fetch_ctrl_if;
  logic [31:0] imem_addr;    // PC word index presented to instruction memory
  logic [31:0] imem_inst;    // combinational instruction for imem_addr
  logic        if_valid;     // if_inst/if_pc hold an instruction for decode
  logic [31:0] if_inst;      // registered fetched instruction
  logic [31:0] if_pc;        // word index of if_inst
  logic        id_ready;     // decode accepts if_inst (0 = hazard stall)
  logic        redirect;     // branch/jump taken
  logic [31:0] redirect_pc;  // redirect target word index
  logic        halt_req;     // stop fetching
  logic        halted;       // fetch unit is in HALT
  logic [31:0] fetch_count;  // completed fetch/decode handshakes
  logic        fault;        // sticky out-of-range redirect flag

  modport master (
    output imem_addr, if_valid, if_inst, if_pc, halted, fetch_count, fault,
    input  imem_inst, id_ready, redirect, redirect_pc, halt_req
  );

  modport slave (
    input  imem_addr, if_valid, if_inst, if_pc, halted, fetch_count, fault,
    output imem_inst, id_ready, redirect, redirect_pc, halt_req
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, one-entry fetch register toward
// decode, redirect with one bubble, halt, handshake counter.
// Ports: clk, rst (sync active-high), bus (fetch_ctrl_if.master).
// Optional FETCH_BOUND_CHECK_EN: out-of-range redirect raises sticky fault and halts.
module fetch_ctrl #(
  parameter int IMEM_DEPTH = 32,
  parameter int RESET_PC   = 0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
);

  localparam int AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PC  = AW'(IMEM_DEPTH - 1);
  localparam logic [AW-1:0] START_PC = AW'(RESET_PC);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic          if_valid;
  logic [31:0]   if_inst;
  logic [31:0]   if_pc;
  logic [31:0]   fetch_count;
  logic          halted;

  logic          handshake;
  logic          advance;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] redirect_tgt;
  logic          unused_hi;

  assign handshake    = if_valid && bus.id_ready;
  assign advance      = !if_valid || bus.id_ready;
  assign pc_next      = (pc == LAST_PC) ? '0 : pc + AW'(1);
  // Targets are taken modulo the memory depth; the dropped bits only matter
  // to the optional bound check.
  assign redirect_tgt = bus.redirect_pc[AW-1:0];
  assign unused_hi    = ^bus.redirect_pc[31:AW];

`ifdef FETCH_BOUND_CHECK_EN
  logic fault_q;
  logic out_of_range;
  assign out_of_range = bus.redirect_pc >= 32'(IMEM_DEPTH);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= START_PC;
      if_valid    <= 1'b0;
      if_inst     <= '0;
      if_pc       <= '0;
      fetch_count <= '0;
      halted      <= 1'b0;
`ifdef FETCH_BOUND_CHECK_EN
      fault_q     <= 1'b0;
`endif
    end else begin
      // A handshake counts even when a redirect squashes the next capture.
      if (handshake) fetch_count <= fetch_count + 32'd1;

      if (bus.redirect) begin
`ifdef FETCH_BOUND_CHECK_EN
        if (out_of_range) begin
          // Bad target: stop cleanly without touching pc.
          fault_q  <= 1'b1;
          state    <= HALT;
          halted   <= 1'b1;
          if_valid <= 1'b0;
        end else begin
          pc       <= redirect_tgt;
          if_valid <= 1'b0;
          state    <= RUN;
          halted   <= 1'b0;
        end
`else
        pc       <= redirect_tgt;
        if_valid <= 1'b0;
        state    <= RUN;
        halted   <= 1'b0;
`endif
      end else begin
        case (state)
          BOOT: state <= RUN;
          RUN: begin
            if (bus.halt_req) begin
              // pc holds; an unaccepted instruction stays for decode.
              state  <= HALT;
              halted <= 1'b1;
              if (handshake) if_valid <= 1'b0;
            end else if (advance) begin
              if_inst  <= bus.imem_inst;
              if_pc    <= 32'(pc);
              if_valid <= 1'b1;
              pc       <= pc_next;
            end
          end
          HALT: begin
            if (handshake) if_valid <= 1'b0;
          end
          default: state <= BOOT;
        endcase
      end
    end
  end

  assign bus.imem_addr   = 32'(pc);
  assign bus.if_valid    = if_valid;
  assign bus.if_inst     = if_inst;
  assign bus.if_pc       = if_pc;
  assign bus.fetch_count = fetch_count;
  assign bus.halted      = halted;
`ifdef FETCH_BOUND_CHECK_EN
  assign bus.fault       = fault_q;
`else
  assign bus.fault       = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: memory returns mem[i]=i, steps are a linear
// sequence with hand-computed expectations checked one edge at a time.
// Ports: none (top level); instantiates fetch_ctrl_if and fetch_ctrl.
module tb_fetch_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.IMEM_DEPTH(32), .RESET_PC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory: mem[i] = i.
  assign bus.imem_inst = bus.imem_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_if(input string tag, input logic v, input int pc, input int cnt);
    chk({tag, "_valid"}, 32'(bus.if_valid), 32'(v));
    if (v) begin
      chk({tag, "_pc"},   bus.if_pc,   32'(pc));
      chk({tag, "_inst"}, bus.if_inst, 32'(pc));
    end
    chk({tag, "_cnt"}, bus.fetch_count, 32'(cnt));
  endtask

  initial begin
    rst             = 1'b1;
    bus.id_ready    = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.halt_req    = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_valid",  32'(bus.if_valid), 0);
    chk("rst_inst",   bus.if_inst, 0);
    chk("rst_pc",     bus.if_pc, 0);
    chk("rst_cnt",    bus.fetch_count, 0);
    chk("rst_halted", 32'(bus.halted), 0);
    chk("rst_fault",  32'(bus.fault), 0);
    chk("rst_addr",   bus.imem_addr, 0);

    // BOOT edge captures nothing, then one instruction per edge with wrap.
    rst = 1'b0;
    tick();
    chk_if("boot", 1'b0, 0, 0);
    for (int n = 0; n < 34; n++) begin
      tick();
      chk_if("seq", 1'b1, n % 32, n);
    end
    chk("seq_addr", bus.imem_addr, 2);

    // Advance to if_pc=5, then stall three cycles.
    for (int n = 34; n < 38; n++) tick();
    chk_if("pre_stall", 1'b1, 5, 37);
    bus.id_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_if("stall", 1'b1, 5, 37);
      chk("stall_addr", bus.imem_addr, 6);
    end
    bus.id_ready = 1'b1;
    tick();
    chk_if("resume", 1'b1, 6, 38);

    // Redirect during stall at if_pc=7: one bubble, then target.
    tick();
    chk_if("pre_redir", 1'b1, 7, 39);
    bus.id_ready = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 32'd20;
    tick();
    chk_if("redir_bubble", 1'b0, 0, 39);
    chk("redir_addr", bus.imem_addr, 20);
    bus.id_ready = 1'b1; bus.redirect = 1'b0;
    tick();
    chk_if("redir_tgt", 1'b1, 20, 39);

    // Redirect together with an accepted handshake still counts it.
    bus.redirect = 1'b1; bus.redirect_pc = 32'd9;
    tick();
    chk_if("redir_hs", 1'b0, 0, 40);
    bus.redirect = 1'b0;
    tick();
    chk_if("redir_hs_tgt", 1'b1, 9, 40);
    tick();
    chk_if("pre_halt", 1'b1, 10, 41);

    // Halt with decode stalled two cycles, then accepted.
    bus.halt_req = 1'b1; bus.id_ready = 1'b0;
    tick();
    chk_if("halt_hold1", 1'b1, 10, 41);
    chk("halt_halted1", 32'(bus.halted), 1);
    bus.halt_req = 1'b0;
    tick();
    chk_if("halt_hold2", 1'b1, 10, 41);
    chk("halt_addr", bus.imem_addr, 11);
    bus.id_ready = 1'b1;
    tick();
    chk_if("halt_drain", 1'b0, 0, 42);
    chk("halt_halted2", 32'(bus.halted), 1);
    tick();
    chk_if("halt_idle", 1'b0, 0, 42);
    chk("halt_idle_addr", bus.imem_addr, 11);
    bus.redirect = 1'b1; bus.redirect_pc = 32'd3;
    tick();
    chk("unhalt", 32'(bus.halted), 0);
    chk_if("unhalt_bubble", 1'b0, 0, 42);
    bus.redirect = 1'b0;
    tick();
    chk_if("unhalt_tgt", 1'b1, 3, 42);
    tick();
    chk_if("pre_oor", 1'b1, 4, 43);

    // Out-of-range redirect target 40.
    bus.redirect = 1'b1; bus.redirect_pc = 32'd40;
    tick();
    chk_if("oor_bubble", 1'b0, 0, 44);
`ifdef FETCH_BOUND_CHECK_EN
    chk("oor_fault",  32'(bus.fault), 1);
    chk("oor_halted", 32'(bus.halted), 1);
    chk("oor_addr",   bus.imem_addr, 5);
`else
    chk("oor_fault",  32'(bus.fault), 0);
    chk("oor_halted", 32'(bus.halted), 0);
    chk("oor_addr",   bus.imem_addr, 8);
`endif
    bus.redirect = 1'b0; bus.id_ready = 1'b0;
    tick();
`ifdef FETCH_BOUND_CHECK_EN
    chk_if("oor_idle", 1'b0, 0, 44);
    chk("oor_fault_sticky", 32'(bus.fault), 1);
`else
    chk_if("oor_resume", 1'b1, 8, 44);
`endif
    bus.redirect = 1'b1; bus.redirect_pc = 32'd12;
    tick();
    chk_if("to12_bubble", 1'b0, 0, 44);
    chk("to12_addr", bus.imem_addr, 12);
    bus.redirect = 1'b0; bus.id_ready = 1'b1;
    tick();
    chk_if("at12", 1'b1, 12, 44);
`ifdef FETCH_BOUND_CHECK_EN
    chk("at12_fault", 32'(bus.fault), 1);
`else
    chk("at12_fault", 32'(bus.fault), 0);
`endif
    chk("at12_halted", 32'(bus.halted), 0);

    // Mid-run reset overrides redirect and halt_req.
    rst = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'd17; bus.halt_req = 1'b1;
    tick();
    chk_if("mid_rst", 1'b0, 0, 0);
    chk("mid_rst_inst",   bus.if_inst, 0);
    chk("mid_rst_pc",     bus.if_pc, 0);
    chk("mid_rst_addr",   bus.imem_addr, 0);
    chk("mid_rst_fault",  32'(bus.fault), 0);
    chk("mid_rst_halted", 32'(bus.halted), 0);
    rst = 1'b0; bus.redirect = 1'b0; bus.halt_req = 1'b0;
    tick();
    chk_if("rest_boot", 1'b0, 0, 0);
    tick();
    chk_if("rest_0", 1'b1, 0, 0);
    tick();
    chk_if("rest_1", 1'b1, 1, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
